fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the MIPS pipeline, sitting directly upstream of the instruction memory. It owns the program counter, drives the instruction-memory address, and captures the returned word into the IF/ID pipeline register for the decode stage. It supports pipeline stall, control-flow redirect from later stages, and halts cleanly when the PC runs past the populated instruction memory. The PC is a word index: instruction memory is indexed directly by PC, and sequential fetch increments it by 1.

## Interface

Parameters:

- RESET_PC, 0: PC value loaded on reset.
- IMEM_DEPTH, 32: number of instruction words; any PC ≥ IMEM_DEPTH is out of range.

Ports:

- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- stall, input, 1: hazard unit hold request.
- redirect, input, 1: taken branch or jump from a later stage.
- redirect_pc, input, 32: target word index, valid while redirect = 1.
- imem_addr, output, 32: address to instruction memory; always equals pc_q (combinational).
- imem_rd, input, 32: instruction word returned combinationally for imem_addr.
- id_instr, output, 32: IF/ID instruction.
- id_pc, output, 32: PC of id_instr.
- id_pc_plus1, output, 32: id_pc + 1.
- id_valid, output, 1: IF/ID holds a real instruction; 0 means bubble.
- halted, output, 1: fetch FSM is in HALT.
- fetch_count, output, 32: number of instructions latched into IF/ID since reset.

## Operation

- FSM states: BOOT, RUN, HALT. Reset state is BOOT.
- BOOT: one cycle only. No fetch occurs, pc_q is held, and id_valid = 0. Next state is RUN unconditionally; redirect is ignored in BOOT.
- RUN: decisions are evaluated in priority order.
  - redirect = 1: pc_q ← redirect_pc and id_valid ← 0; id_instr, id_pc and id_pc_plus1 hold. This applies regardless of stall.
  - Otherwise, if stall = 1: pc_q and all IF/ID fields hold; fetch_count holds.
  - Otherwise, if pc_q ≥ IMEM_DEPTH: id_valid ← 0, pc_q holds, and the next state is HALT.
  - Otherwise, normal fetch:
    - id_instr ← imem_rd, id_pc ← pc_q, id_pc_plus1 ← pc_q + 1, id_valid ← 1.
    - pc_q ← pc_q + 1.
    - fetch_count ← fetch_count + 1.
- HALT: halted = 1, id_valid = 0, and pc_q holds; stall is ignored. redirect = 1 loads pc_q ← redirect_pc and moves the FSM to RUN. An out-of-range target re-enters HALT on the first unstalled RUN cycle.
- Arithmetic: pc_q + 1 and fetch_count wrap modulo 2^32. The range check is an unsigned compare.

## Timing

- Reset values, applied asynchronously:
  - pc_q = RESET_PC.
  - id_instr = 0, id_pc = 0, id_pc_plus1 = 0, id_valid = 0.
  - fetch_count = 0, halted = 0, state = BOOT.
- imem_addr has zero latency from pc_q.
- An instruction at PC p appears on the id_* outputs the cycle after pc_q = p, provided it is unstalled and not redirected.
- Redirect latency: redirect asserted in cycle n gives pc_q = redirect_pc in cycle n+1. The target instruction appears on id_* in cycle n+2. Cycle n+1 presents a bubble.
- Stall is level-sensitive: each stalled cycle extends the hold by one cycle. There is no skid.
- If reset asserts mid-operation, all state clears immediately. The first fetch occurs two rising edges after reset deasserts (BOOT, then RUN).

## Structure

- The shared package mips_pkg holds:
  - WORD_W = 32.
  - The fetch_state_t enum {BOOT, RUN, HALT}.
  - The default RESET_PC constant, for reuse by decode and the hazard unit.
- Sub-module if_id_reg holds id_instr, id_pc, id_pc_plus1 and id_valid. Its controls are:
  - load: capture a new instruction.
  - bubble: clear valid only.
  - Hold: the default when neither control is asserted.
- The PC register, FSM, range check and counter stay in fetch_stage.

## Test plan

- Reset then run with no stall: with imem_rd = word at address, the cycle after BOOT gives id_pc = 0, id_valid = 1, fetch_count = 1. Three consecutive fetches give id_pc = 0, 1, 2 and fetch_count = 3.
- Stall for 2 cycles while pc_q = 3: imem_addr stays 3, id_* frozen, fetch_count unchanged. On release, id_pc = 3 the next cycle.
- Redirect to 8 while pc_q = 4, with stall = 1 in the same cycle: pc_q = 8 next cycle with id_valid = 0. The cycle after that gives id_pc = 8 and id_pc_plus1 = 9.
- With IMEM_DEPTH = 11, run to pc_q = 11: id_valid = 0 and halted = 1 next cycle, with pc_q held at 11. A redirect to 2 gives halted = 0, then id_pc = 2 with id_valid = 1.
- Reset asserted mid-run at pc_q = 6 with id_valid = 1: all outputs return to reset values immediately (pc_q = 0, fetch_count = 0, id_valid = 0). After deassert, one BOOT cycle passes before id_pc = 0.
- Redirect asserted during BOOT is ignored: the first fetched id_pc = RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline types and constants
package mips_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t DEFAULT_RESET_PC = '0;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_t;

  // PC is a word index, so sequential fetch advances by one (wrapping mod 2^32).
  function automatic word_t pc_inc(input word_t pc);
    return pc + word_t'(1);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, bubble and hold
module if_id_reg
  import mips_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  bubble,
  input  word_t instr,
  input  word_t pc,
  input  word_t pc_plus1,
  output word_t id_instr,
  output word_t id_pc,
  output word_t id_pc_plus1,
  output logic  id_valid
);

  // A bubble only drops valid; the payload keeps its last captured value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_instr    <= '0;
      id_pc       <= '0;
      id_pc_plus1 <= '0;
      id_valid    <= 1'b0;
    end else if (load) begin
      id_instr    <= instr;
      id_pc       <= pc;
      id_pc_plus1 <= pc_plus1;
      id_valid    <= 1'b1;
    end else if (bubble) begin
      id_valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, fetch FSM, range check, IF/ID capture
module fetch_stage
  import mips_pkg::*;
#(
  parameter word_t RESET_PC   = DEFAULT_RESET_PC,
  parameter int    IMEM_DEPTH = 32
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_pc,
  output word_t imem_addr,
  input  word_t imem_rd,
  output word_t id_instr,
  output word_t id_pc,
  output word_t id_pc_plus1,
  output logic  id_valid,
  output logic  halted,
  output word_t fetch_count
);

  localparam word_t DEPTH_W = word_t'(IMEM_DEPTH);

  fetch_state_t state;
  word_t        pc_q;
  word_t        pc_plus1;
  logic         in_range;
  logic         run;
  logic         do_fetch;
  logic         do_bubble;

  assign imem_addr = pc_q;
  assign pc_plus1  = pc_inc(pc_q);
  assign in_range  = (pc_q < DEPTH_W);
  assign run       = (state == RUN);

  // Redirect outranks stall; an unstalled out-of-range PC bubbles on its way to HALT.
  assign do_fetch  = run && !redirect && !stall && in_range;
  assign do_bubble = run && (redirect || (!stall && !in_range));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      pc_q        <= RESET_PC;
      fetch_count <= '0;
      halted      <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN: begin
          if (redirect) begin
            pc_q <= redirect_pc;
          end else if (stall) begin
            pc_q <= pc_q;
          end else if (!in_range) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            pc_q        <= pc_plus1;
            fetch_count <= fetch_count + word_t'(1);
          end
        end
        HALT: begin
          if (redirect) begin
            pc_q   <= redirect_pc;
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= BOOT;
          halted <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .reset       (reset),
    .load        (do_fetch),
    .bubble      (do_bubble),
    .instr       (imem_rd),
    .pc          (pc_q),
    .pc_plus1    (pc_plus1),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus1 (id_pc_plus1),
    .id_valid    (id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed plus randomized check of fetch_stage against a reference model
module tb_fetch_stage;

  localparam int DEPTH = 11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus1;
  logic        id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [DEPTH];

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_idpc;
  logic [31:0] m_plus1;
  logic        m_valid;
  logic        m_halted;
  logic        m_booting;
  logic [31:0] m_count;

  int checks = 0;
  int errors = 0;

  assign imem_rd = (imem_addr < 32'(DEPTH)) ? mem[imem_addr[3:0]] : 32'hBAD0_0BAD;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC   (32'd0),
    .IMEM_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus1 (id_pc_plus1),
    .id_valid    (id_valid),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("imem_addr",   imem_addr,           m_pc);
    chk("id_instr",    id_instr,            m_instr);
    chk("id_pc",       id_pc,               m_idpc);
    chk("id_pc_plus1", id_pc_plus1,         m_plus1);
    chk("id_valid",    {31'd0, id_valid},   {31'd0, m_valid});
    chk("halted",      {31'd0, halted},     {31'd0, m_halted});
    chk("fetch_count", fetch_count,         m_count);
  endtask

  task automatic model_reset();
    m_pc      = 32'd0;
    m_instr   = 32'd0;
    m_idpc    = 32'd0;
    m_plus1   = 32'd0;
    m_valid   = 1'b0;
    m_halted  = 1'b0;
    m_booting = 1'b1;
    m_count   = 32'd0;
  endtask

  // One clock: apply inputs, advance the model by the fetch rules, then compare after the edge.
  task automatic step(input logic s, input logic r, input logic [31:0] t);
    stall       = s;
    redirect    = r;
    redirect_pc = t;
    if (m_booting) begin
      m_booting = 1'b0;
    end else if (m_halted) begin
      if (r) begin
        m_pc     = t;
        m_halted = 1'b0;
      end
    end else if (r) begin
      m_pc    = t;
      m_valid = 1'b0;
    end else if (!s) begin
      if (m_pc >= 32'(DEPTH)) begin
        m_valid  = 1'b0;
        m_halted = 1'b1;
      end else begin
        m_instr = mem[m_pc[3:0]];
        m_idpc  = m_pc;
        m_plus1 = m_pc + 32'd1;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd1;
        m_count = m_count + 32'd1;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic mid_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    model_reset();

    @(posedge clk);
    #1;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;

    step(1'b0, 1'b1, 32'd5);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);

    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);

    step(1'b1, 1'b1, 32'd8);
    step(1'b0, 1'b0, 32'd0);

    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'd2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0);

    mid_reset();
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        mid_reset();
      end else begin
        step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
             32'($urandom_range(0, 14)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
